uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, the inverse of the team's UART_TX: 8 data bits, 1 start bit, 1 stop bit, no parity, LSB first.
- Defaults: 115200 baud from a 25 MHz clock.
- Synchronises the asynchronous serial line, validates the start bit at mid-bit, then samples data and stop at bit centres.
- Presents each received byte with a one-cycle valid strobe.
- Sits at the pin side of the host link and feeds downstream command/FIFO logic.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz
- BAUD_RATE, 115200, line rate in baud
- Derived localparam CLKS_PER_BAUD = CLK_FREQ/BAUD_RATE (integer divide); HALF_BAUD = CLKS_PER_BAUD/2; counter width = $clog2(CLKS_PER_BAUD)

Ports:
- i_clk  input  1  system clock, all logic on rising edge
- i_reset_n  input  1  synchronous, active-low reset
- i_serial  input  1  asynchronous serial line, idle high
- o_data  output  8  last correctly framed byte; held until the next good byte
- o_rx_dv  output  1  one-cycle pulse: o_data updated this cycle
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_rx_busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - FSM to IDLE; counters to 0; shift register to 0.
  - o_data = 8'h00; o_rx_dv = 0; o_frame_err = 0; o_rx_busy = 0.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame abandons the frame with no strobe.
- Synchroniser: 2-flop on i_serial, giving s_rx. All FSM decisions use s_rx only.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: baud counter and bit index held at 0. When s_rx = 0, go to START.
- START:
  - Baud counter increments each cycle.
  - When counter = HALF_BAUD-1, sample s_rx.
  - Sample 0: go to DATA, counter to 0.
  - Sample 1: false start (glitch); return to IDLE with no pulse.
- DATA:
  - When counter = CLKS_PER_BAUD-1, sample into shift[bit_idx] (LSB first) and clear the counter.
  - bit_idx 0..7; after bit 7 is sampled, go to STOP.
- STOP: when counter = CLKS_PER_BAUD-1, sample s_rx.
  - Sample 1: o_data <= shift, o_rx_dv = 1 for exactly one cycle, go to IDLE.
  - Sample 0: o_frame_err = 1 for one cycle, o_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until s_rx = 1, then go to IDLE. This prevents a break condition from re-triggering frames.
- Timing:
  - o_rx_dv / o_frame_err assert HALF_BAUD + 9*CLKS_PER_BAUD + 3 clocks (±1) after the i_serial falling edge.
  - A new start bit is accepted on the first IDLE cycle after the strobe, so back-to-back frames with a single stop bit are received without loss.
- Output relationships:
  - o_rx_dv and o_frame_err are never high together.
  - o_rx_busy is low in the strobe cycle's following state (IDLE) and high in WAIT_IDLE.
- Illegal state encoding: next state IDLE.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Keep a 3-deep history of s_rx.
  - Every sample point (start check, data, stop) uses the majority of the last 3 s_rx values.
  - IDLE start detection still uses s_rx alone.
  - Requires CLKS_PER_BAUD >= 8; the design contains a compile-time check.
  - Latency unchanged.
- Undefined: single sample of s_rx at each sample point; no history registers.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (3-bit enum/localparams).
  - UART_DATA_BITS = 8.
  - A function computing clocks-per-baud from CLK_FREQ/BAUD_RATE, for reuse by UART_TX.
- Sub-module uart_rx_sync:
  - 2-flop synchroniser plus the optional 3-sample majority history.
  - Outputs s_rx and the sample value.

Test Plan (CLK_FREQ=16, BAUD_RATE=1 → CLKS_PER_BAUD=16 unless noted):
- Send 8'hA5 with a good stop bit → o_rx_dv pulses exactly 1 cycle, o_data=8'hA5, o_frame_err stays 0, o_rx_busy falls at the strobe.
- Back-to-back 8'h00 then 8'hFF, no idle gap → two o_rx_dv pulses 160 clocks (±1) apart, o_data = 8'h00 then 8'hFF.
- Send 8'h3C with stop bit driven low, line held low 40 more clocks, then high → one o_frame_err pulse, no o_rx_dv, o_data keeps its previous value, o_rx_busy high until the line returns high.
- 4-clock low glitch on the idle line → no strobe; FSM back in IDLE (o_rx_busy low) within HALF_BAUD+3 clocks.
- Assert i_reset_n=0 during data bit 4 of 8'h5A, release, then send 8'hC3 → no strobe for the aborted frame, o_data=8'h00 until 8'hC3 is received correctly.
- With UART_RX_MAJORITY_EN, send 8'h96 with a 1-clock inverted spike at every bit centre → o_data=8'h96, no frame error. Without the macro, the same stimulus is not required to pass.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, data width and baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_rx_state_t;

    // Integer divide; the fractional remainder becomes a small per-frame drift.
    function automatic int calc_clks_per_baud(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; with UART_RX_MAJORITY_EN it also keeps
// a 3-deep history and presents the majority vote as the sample value.
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_serial,
    output logic o_s_rx,
    output logic o_sample
);

    logic r_meta;
    logic r_sync;

    // Flops reset to 1 so the line looks idle coming out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_serial;
            r_sync <= r_meta;
        end
    end

    assign o_s_rx = r_sync;

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync};
        end
    end

    assign o_sample = (r_sync & r_hist[0]) | (r_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
`else
    assign o_sample = r_sync;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first. Define UART_RX_MAJORITY_EN to vote each sample point
// over the last three synchronised line values (needs CLKS_PER_BAUD >= 8).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_serial,
    output logic [UART_DATA_BITS-1:0] o_data,
    output logic                      o_rx_dv,
    output logic                      o_frame_err,
    output logic                      o_rx_busy
);

    localparam int CLKS_PER_BAUD = calc_clks_per_baud(CLK_FREQ, BAUD_RATE);
    localparam int HALF_BAUD     = CLKS_PER_BAUD / 2;
    localparam int CNT_W         = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
    localparam int IDX_W         = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF_BAUD - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BAUD - 1);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
    generate
        if (CLKS_PER_BAUD < 8) begin : g_baud_check
            $error("uart_rx: majority sampling needs CLKS_PER_BAUD >= 8");
        end
    endgenerate
`endif

    logic w_s_rx;
    logic w_sample;

    uart_rx_sync u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_serial  (i_serial),
        .o_s_rx    (w_s_rx),
        .o_sample  (w_sample)
    );

    uart_rx_state_t              r_state;
    uart_rx_state_t              w_next_state;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_next;
    logic [IDX_W-1:0]            r_bit_idx;
    logic [IDX_W-1:0]            w_bit_next;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [UART_DATA_BITS-1:0]   r_data;
    logic                        r_rx_dv;
    logic                        r_frame_err;
    logic                        w_shift_en;
    logic                        w_good;
    logic                        w_bad;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_rx_dv     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_next;
            r_bit_idx   <= w_bit_next;
            r_rx_dv     <= w_good;
            r_frame_err <= w_bad;
            if (w_shift_en) begin
                r_shift[r_bit_idx] <= w_sample;
            end
            if (w_good) begin
                r_data <= r_shift;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_en   = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = '0;
                if (!w_s_rx) begin
                    w_next_state = ST_START;
                end
            end
            ST_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next   = '0;
                    // A line back high at mid start bit was only a glitch.
                    w_next_state = w_sample ? ST_IDLE : ST_DATA;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_BIT) begin
                        w_bit_next   = '0;
                        w_next_state = ST_STOP;
                    end else begin
                        w_bit_next = r_bit_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next = '0;
                    if (w_sample) begin
                        w_good       = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_next_state = ST_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                w_cnt_next = '0;
                // Hold off through a break so a long low line cannot start new frames.
                if (w_s_rx) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_dv     = r_rx_dv;
    assign o_frame_err = r_frame_err;
    assign o_rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BAUD = 16; expected values are hand-derived.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = HALF + 9 * CPB + 3;

    logic       i_clk;
    logic       i_reset_n;
    logic       i_serial;
    logic [7:0] o_data;
    logic       o_rx_dv;
    logic       o_frame_err;
    logic       o_rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int dv_count    = 0;
    int fe_count    = 0;
    int last_dv_cyc = 0;
    int last_fe_cyc = 0;
    logic dv_busy   = 1'b1;
    logic fe_busy   = 1'b0;
    logic prev_dv   = 1'b0;
    logic prev_fe   = 1'b0;

    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_FREQ  (16),
        .BAUD_RATE (1)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_serial    (i_serial),
        .o_data      (o_data),
        .o_rx_dv     (o_rx_dv),
        .o_frame_err (o_frame_err),
        .o_rx_busy   (o_rx_busy)
    );

    // Clock and cycle counter
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Driver tasks: every call starts and ends 1 time unit after a rising edge.
    task automatic drive_bit(input logic v, input int n);
        i_serial = v;
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    int fall_cyc = 0;

    task automatic send_frame(input logic [7:0] b, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
        drive_bit(stop, CPB);
        i_serial = 1'b1;
    endtask

    // Scoreboard: every strobe is checked against the expected queue.
    always @(negedge i_clk) begin
        if (o_rx_dv || o_frame_err) chk("dv_fe_exclusive", {31'd0, o_rx_dv & o_frame_err}, 0);
        if (o_rx_dv) begin
            dv_count++;
            last_dv_cyc = cyc;
            dv_busy = o_rx_busy;
            chk("dv_one_cycle", {31'd0, prev_dv}, 0);
            if (exp_q.size() == 0) begin
                chk("dv_unexpected", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                chk("rx_data", {24'd0, o_data}, {24'd0, e});
            end
        end
        if (o_frame_err) begin
            fe_count++;
            last_fe_cyc = cyc;
            fe_busy = o_rx_busy;
            chk("fe_one_cycle", {31'd0, prev_fe}, 0);
        end
        prev_dv = o_rx_dv;
        prev_fe = o_frame_err;
    end

    int t0;
    int glitch_cyc;

    initial begin
        // Reset
        i_reset_n = 1'b0;
        i_serial  = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        drive_bit(1'b1, 4);
        chk("reset_data", {24'd0, o_data}, 0);
        chk("reset_dv", {31'd0, o_rx_dv}, 0);
        chk("reset_fe", {31'd0, o_frame_err}, 0);
        chk("reset_busy", {31'd0, o_rx_busy}, 0);

        // Single good frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 20);
        chk("a5_dv_count", dv_count, 1);
        chk("a5_data", {24'd0, o_data}, 32'hA5);
        chk("a5_fe_count", fe_count, 0);
        chk_range("a5_latency", last_dv_cyc - fall_cyc, LAT - 1, LAT + 1);
        chk("a5_busy_at_strobe", {31'd0, dv_busy}, 0);

        // Back-to-back frames with no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        t0 = last_dv_cyc;
        chk("b2b_first_dv", dv_count, 2);
        send_frame(8'hFF, 1'b1);
        drive_bit(1'b1, 20);
        chk("b2b_dv_count", dv_count, 3);
        chk_range("b2b_interval", last_dv_cyc - t0, 10 * CPB - 1, 10 * CPB + 1);
        chk("b2b_data", {24'd0, o_data}, 32'hFF);

        // Framing error followed by a held-low line
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 20);
        chk("fe_count", fe_count, 1);
        chk_range("fe_latency", last_fe_cyc - fall_cyc, LAT - 1, LAT + 1);
        chk("fe_busy_at_strobe", {31'd0, fe_busy}, 1);
        chk("fe_busy_held_low", {31'd0, o_rx_busy}, 1);
        drive_bit(1'b0, 20);
        chk("fe_busy_still_low", {31'd0, o_rx_busy}, 1);
        drive_bit(1'b1, 4);
        chk("fe_busy_released", {31'd0, o_rx_busy}, 0);
        chk("fe_no_dv", dv_count, 3);
        chk("fe_data_kept", {24'd0, o_data}, 32'hFF);
        chk("fe_single", fe_count, 1);

        // Short glitch on an idle line
        drive_bit(1'b1, 10);
        glitch_cyc = cyc;
        drive_bit(1'b0, 4);
        chk("glitch_busy_start", {31'd0, o_rx_busy}, 1);
        drive_bit(1'b1, HALF + 3 - 4);
        chk("glitch_cyc_offset", cyc - glitch_cyc, HALF + 3);
        chk("glitch_back_idle", {31'd0, o_rx_busy}, 0);
        drive_bit(1'b1, 200);
        chk("glitch_no_dv", dv_count, 3);
        chk("glitch_no_fe", fe_count, 1);

        // Reset in the middle of data bit 4, then a clean frame
        drive_bit(1'b0, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b0, CPB);
        drive_bit(1'b1, CPB);
        drive_bit(1'b1, HALF);
        i_reset_n = 1'b0;
        drive_bit(1'b1, 3);
        chk("abort_dv_in_reset", {31'd0, o_rx_dv}, 0);
        i_reset_n = 1'b1;
        drive_bit(1'b1, 2);
        chk("abort_data_zero", {24'd0, o_data}, 0);
        chk("abort_busy", {31'd0, o_rx_busy}, 0);
        drive_bit(1'b1, 200);
        chk("abort_no_dv", dv_count, 3);
        chk("abort_data_still_zero", {24'd0, o_data}, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        drive_bit(1'b1, 20);
        chk("c3_dv_count", dv_count, 4);
        chk("c3_data", {24'd0, o_data}, 32'hC3);

`ifdef UART_RX_MAJORITY_EN
        // One-clock inverted spike at every bit centre
        begin
            logic [9:0] bits;
            bits = {1'b1, 8'h96, 1'b0};
            exp_q.push_back(8'h96);
            for (int i = 0; i < 10; i++) begin
                drive_bit(bits[i], HALF);
                drive_bit(~bits[i], 1);
                drive_bit(bits[i], CPB - HALF - 1);
            end
            drive_bit(1'b1, 20);
            chk("maj_dv_count", dv_count, 5);
            chk("maj_data", {24'd0, o_data}, 32'h96);
            chk("maj_no_fe", fe_count, 1);
        end
`endif

        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
